// File: rtl/instr_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// Module : rv_defs (package)
// Brief  : Shared FSM encoding, NOP word and instruction field positions.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rv_defs;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] c_nop_inst = 32'h0000_0013;

  localparam int c_opc_lsb = 2;
  localparam int c_opc_msb = 6;
  localparam int c_f3_lsb  = 12;
  localparam int c_f3_msb  = 14;
  localparam int c_f7_bit  = 30;

endpackage : rv_defs

`default_nettype wire

// File: rtl/instr_fetch_unit_next_pc.sv
// ----------------------------------------------------------------------------
// Module : next_pc_logic
// Brief  : Combinational branch/jump resolution and target alignment check.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module next_pc_logic
  import rv_defs::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic        branch_i,
  input  logic        branchn_i,
  input  logic        jump_i,
  input  logic        zero_i,
  output logic [31:0] next_pc_o,
  output logic        misalign_o
);

  logic        w_taken;
  logic [31:0] w_target;
  logic [31:0] w_seq;

  // Jump and both branch flavours share one adder; either branch condition may take.
  assign w_taken    = jump_i | (branch_i & zero_i) | (branchn_i & ~zero_i);
  assign w_target   = pc_i + imm_i;
  assign w_seq      = pc_i + 32'd4;
  assign next_pc_o  = w_taken ? w_target : w_seq;
  assign misalign_o = w_taken & (|w_target[1:0]);

endmodule : next_pc_logic

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// Module : instr_fetch_unit
// Brief  : Fetch stage owning PC/IR, imem handshake, timeout and trap redirect.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit
  import rv_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        retire,
  input  logic        Branch,
  input  logic        BranchN,
  input  logic        Jump,
  input  logic        zero,
  input  logic [31:0] imm,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [4:0]  OPcode,
  output logic [2:0]  Fun3,
  output logic        Fun7,
  output logic        misalign_err,
  output logic        bus_err,
  output logic [31:0] instr_count
);

  localparam int             CW          = $clog2(MAX_WAIT) + 1;
  localparam logic [CW-1:0]  c_wait_last = CW'(MAX_WAIT - 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          misalign_q, misalign_d;
  logic          bus_err_q, bus_err_d;
  logic [31:0]   instr_count_q, instr_count_d;

  logic [31:0]   w_next_pc;
  logic          w_misalign;

  next_pc_logic u_next_pc (
    .pc_i       (pc_q),
    .imm_i      (imm),
    .branch_i   (Branch),
    .branchn_i  (BranchN),
    .jump_i     (Jump),
    .zero_i     (zero),
    .next_pc_o  (w_next_pc),
    .misalign_o (w_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      ir_q          <= c_nop_inst;
      cnt_q         <= '0;
      misalign_q    <= 1'b0;
      bus_err_q     <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      cnt_q         <= cnt_d;
      misalign_q    <= misalign_d;
      bus_err_q     <= bus_err_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    cnt_d         = cnt_q;
    misalign_d    = misalign_q;
    bus_err_d     = bus_err_q;
    instr_count_d = instr_count_q;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          cnt_d   = '0;
          state_d = ST_EXEC;
        end else if (cnt_q == c_wait_last) begin
          // Timed out: refetch from the trap vector, request stays up.
          pc_d      = TRAP_VEC;
          bus_err_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_EXEC: begin
        if (retire) begin
          instr_count_d = instr_count_q + 32'd1;
          state_d       = ST_FETCH;
          if (w_misalign) begin
            pc_d       = TRAP_VEC;
            misalign_d = 1'b1;
          end else begin
            pc_d = w_next_pc;
          end
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign imem_req     = (state_q == ST_FETCH);
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign inst         = ir_q;
  assign inst_valid   = (state_q == ST_EXEC);
  assign OPcode       = ir_q[c_opc_msb:c_opc_lsb];
  assign Fun3         = ir_q[c_f3_msb:c_f3_lsb];
  assign Fun7         = ir_q[c_f7_bit];
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;
  assign instr_count  = instr_count_q;

endmodule : instr_fetch_unit

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// Module : tb_instr_fetch_unit
// Brief  : Directed table-driven bench for instr_fetch_unit.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        retire;
  logic        Branch;
  logic        BranchN;
  logic        Jump;
  logic        zero;
  logic [31:0] imm;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic [4:0]  OPcode;
  logic [2:0]  Fun3;
  logic        Fun7;
  logic        misalign_err;
  logic        bus_err;
  logic [31:0] instr_count;

  instr_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .retire       (retire),
    .Branch       (Branch),
    .BranchN      (BranchN),
    .Jump         (Jump),
    .zero         (zero),
    .imm          (imm),
    .pc           (pc),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .OPcode       (OPcode),
    .Fun3         (Fun3),
    .Fun7         (Fun7),
    .misalign_err (misalign_err),
    .bus_err      (bus_err),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        br;
    logic        brn;
    logic        jmp;
    logic        zf;
    logic [31:0] imm;
    logic [4:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] next_pc;
    logic        mis;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl();
    retire  = 1'b0;
    Branch  = 1'b0;
    BranchN = 1'b0;
    Jump    = 1'b0;
    zero    = 1'b0;
    imm     = 32'h0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req},     32'd0);
    chk({tag, "_pc"},    pc,                     32'h0);
    chk({tag, "_inst"},  inst,                   32'h0000_0013);
    chk({tag, "_valid"}, {31'd0, inst_valid},   32'd0);
    chk({tag, "_mis"},   {31'd0, misalign_err}, 32'd0);
    chk({tag, "_bus"},   {31'd0, bus_err},      32'd0);
    chk({tag, "_cnt"},   instr_count,            32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h0050_0093, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 5'b00100, 3'b000, 1'b0, 32'h0000_0010, 1'b0};
    vecs[1]  = '{32'h0020_8463, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 5'b11000, 3'b000, 1'b0, 32'h0000_0014, 1'b0};
    vecs[2]  = '{32'h0100_00EF, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 5'b11011, 3'b000, 1'b0, 32'h0000_0010, 1'b0};
    vecs[3]  = '{32'h0020_8463, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 5'b11000, 3'b000, 1'b0, 32'h0000_0030, 1'b0};
    vecs[4]  = '{32'h0020_9463, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 5'b11000, 3'b001, 1'b0, 32'h0000_0040, 1'b0};
    vecs[5]  = '{32'h0100_00EF, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 5'b11011, 3'b000, 1'b0, 32'h0000_0038, 1'b0};
    vecs[6]  = '{32'h0020_9463, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 5'b11000, 3'b001, 1'b0, 32'h0000_003C, 1'b0};
    vecs[7]  = '{32'h4020_D433, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 5'b01100, 3'b101, 1'b1, 32'h0000_0040, 1'b0};
    vecs[8]  = '{32'h0100_00EF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 5'b11011, 3'b000, 1'b0, 32'h0000_0048, 1'b0};
    vecs[9]  = '{32'h0100_00EF, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFB4, 5'b11011, 3'b000, 1'b0, 32'hFFFF_FFFC, 1'b0};
    vecs[10] = '{32'h0000_7013, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 5'b00100, 3'b111, 1'b0, 32'h0000_0000, 1'b0};
    vecs[11] = '{32'h0100_00EF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 5'b11011, 3'b000, 1'b0, 32'h0000_0040, 1'b0};
    vecs[12] = '{32'h0100_00EF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0006, 5'b11011, 3'b000, 1'b0, 32'h0000_0100, 1'b1};
    vecs[13] = '{32'h0020_8463, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 5'b11000, 3'b000, 1'b0, 32'h0000_0120, 1'b1};
    vecs[14] = '{32'h0020_8463, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0003, 5'b11000, 3'b000, 1'b0, 32'h0000_0124, 1'b1};

    rst_n      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    idle_ctl();
    tick();
    tick();
    chk_reset_state("reset");
    chk("reset_opcode", {27'd0, OPcode}, 32'h0000_0004);
    rst_n = 1'b1;
    tick();
    // First FETCH cycle: memory not ready yet
    chk("boot_req",  {31'd0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr,          32'h0);
    tick();
    chk("wait1_req",   {31'd0, imem_req},   32'd1);
    chk("wait1_valid", {31'd0, inst_valid}, 32'd0);

    exp_pc = 32'h0;
    for (int i = 0; i < NV; i++) begin
      chk("f_req",  {31'd0, imem_req}, 32'd1);
      chk("f_addr", imem_addr,          exp_pc);
      imem_ready = 1'b1;
      imem_rdata = vecs[i].rdata;
      tick();
      imem_ready = 1'b0;
      imem_rdata = 32'h0;
      chk("e_valid", {31'd0, inst_valid}, 32'd1);
      chk("e_req",   {31'd0, imem_req},   32'd0);
      chk("e_inst",  inst,                 vecs[i].rdata);
      chk("e_pc",    pc,                   exp_pc);
      chk("e_opc",   {27'd0, OPcode},      {27'd0, vecs[i].opc});
      chk("e_f3",    {29'd0, Fun3},        {29'd0, vecs[i].f3});
      chk("e_f7",    {31'd0, Fun7},        {31'd0, vecs[i].f7});
      retire  = 1'b1;
      Branch  = vecs[i].br;
      BranchN = vecs[i].brn;
      Jump    = vecs[i].jmp;
      zero    = vecs[i].zf;
      imm     = vecs[i].imm;
      tick();
      // Controls are garbage after retire and must not matter
      idle_ctl();
      Jump = 1'b1;
      imm  = 32'h0000_0203;
      chk("r_req",   {31'd0, imem_req},     32'd1);
      chk("r_valid", {31'd0, inst_valid},   32'd0);
      chk("r_addr",  imem_addr,              vecs[i].next_pc);
      chk("r_mis",   {31'd0, misalign_err}, {31'd0, vecs[i].mis});
      chk("r_count", instr_count,            32'(i + 1));
      exp_pc = vecs[i].next_pc;
    end

    // Timeout while retire is (ignored) high in FETCH
    idle_ctl();
    retire = 1'b1;
    Jump   = 1'b1;
    imm    = 32'h0000_0040;
    repeat (15) tick();
    chk("to_pre_addr", imem_addr,         32'h0000_0124);
    chk("to_pre_bus",  {31'd0, bus_err}, 32'd0);
    chk("to_pre_cnt",  instr_count,       32'd15);
    tick();
    chk("to_bus",   {31'd0, bus_err},    32'd1);
    chk("to_addr",  imem_addr,            32'h0000_0100);
    chk("to_req",   {31'd0, imem_req},   32'd1);
    chk("to_valid", {31'd0, inst_valid}, 32'd0);
    idle_ctl();
    imem_ready = 1'b1;
    imem_rdata = 32'h0050_0093;
    tick();
    imem_rdata = 32'h0000_7013;
    tick();
    imem_ready = 1'b0;
    chk("exec_ignore_rdy_inst",  inst,                 32'h0050_0093);
    chk("exec_ignore_rdy_valid", {31'd0, inst_valid}, 32'd1);
    chk("exec_pc",               pc,                   32'h0000_0100);

    // Retire counter wrap
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    if (instr_count === 32'hFFFF_FFFF) begin
      retire = 1'b1;
      tick();
      retire = 1'b0;
      chk("wrap_count", instr_count, 32'h0);
      chk("wrap_addr",  imem_addr,   32'h0000_0104);
    end

    // Async reset in the middle of a fetch
    idle_ctl();
    rst_n = 1'b0;
    #1;
    chk_reset_state("rst_fetch");
    tick();
    rst_n = 1'b1;
    tick();
    imem_ready = 1'b1;
    imem_rdata = 32'h0100_00EF;
    tick();
    imem_ready = 1'b0;
    retire = 1'b1;
    Jump   = 1'b1;
    imm    = 32'h0000_0020;
    tick();
    idle_ctl();
    imem_ready = 1'b1;
    imem_rdata = 32'h4020_D433;
    tick();
    imem_ready = 1'b0;
    chk("pre_rst_exec_pc",    pc,                   32'h0000_0020);
    chk("pre_rst_exec_valid", {31'd0, inst_valid}, 32'd1);
    // Async reset in the middle of execute
    rst_n = 1'b0;
    #1;
    chk_reset_state("rst_exec");
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_req",  {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr,          32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_instr_fetch_unit

`default_nettype wire
